silife_grid_loader_rw: RTL and testbench



---
 rtl/silife_loader_pkg.sv | 23 ++
 rtl/silife_sync_edge.sv | 43 ++++
 rtl/silife_grid_loader_rw.sv | 229 ++++++++++++++++++++++
 tb/tb_silife_grid_loader_rw.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_loader_pkg.sv
// Shared types and constants for the silife grid loader.
//   loader_state_e      : frame-decoding FSM states
//   CMD_WRITE/CMD_READ  : value of the command bit that follows the start bit
//   ROW_ADDR_FRAME_BITS : row-address field length on the wire
package silife_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIGURE,
    ST_CMD,
    ST_SEG_ADDR,
    ST_ROW_ADDR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } loader_state_e;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  localparam int ROW_ADDR_FRAME_BITS = 16;

endpackage

// File: rtl/silife_sync_edge.sv
// Pin synchroniser with edge detection.
//   clk, reset : system clock, asynchronous active-high reset
//   i_pin      : asynchronous pin
//   o_sync     : pin after STAGES flops (reset value RESET_VAL)
//   o_rise     : one-clk strobe on a synchronised 0->1 transition
//   o_fall     : one-clk strobe on a synchronised 1->0 transition
module silife_sync_edge
  import silife_loader_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              past_q, past_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_pin};
    past_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      past_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      past_q <= past_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_rise = o_sync & ~past_q;
  assign o_fall = ~o_sync & past_q;

endmodule

// File: rtl/silife_grid_loader_rw.sv
// Serial grid loader with segment addressing, row wrap and optional read-back.
//   clk, reset          : system clock, asynchronous active-high reset
//   i_load_cs/clk/data  : serial frame pins (cs active low), asynchronous
//   o_load_data         : registered serial out / daisy-chain pass-through
//   i_row_cells         : grid cell states of row o_row_select
//   o_selected          : this segment addressed and in Write/Read
//   o_row_select        : row being written or read
//   o_set_cells         : one-clk set pulses
//   o_clear_cells       : one-clk clear pulses
//   o_dbg_local_address : configured segment address
// Build option: define SILIFE_LOADER_READBACK_EN to include the Read state,
// shadow row and i_row_cells sampling; otherwise read commands are ignored.
module silife_grid_loader_rw
  import silife_loader_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int SEG_BITS    = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load_cs,
  input  logic                      i_load_clk,
  input  logic                      i_load_data,
  output logic                      o_load_data,
  input  logic [WIDTH-1:0]          i_row_cells,
  output logic                      o_selected,
  output logic [$clog2(HEIGHT)-1:0] o_row_select,
  output logic [WIDTH-1:0]          o_set_cells,
  output logic [WIDTH-1:0]          o_clear_cells,
  output logic [SEG_BITS-1:0]       o_dbg_local_address
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int MAXF  = (SEG_BITS > ROW_ADDR_FRAME_BITS) ? SEG_BITS : ROW_ADDR_FRAME_BITS;
  localparam int CNT_W = $clog2(MAXF + 1);

  logic cs_s, clk_rise, clk_fall, data_s;
  logic [1:0] unused_cs_edges, unused_data_edges;
  logic       unused_clk_sync;

  silife_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .i_pin(i_load_cs),
    .o_sync(cs_s), .o_rise(unused_cs_edges[0]), .o_fall(unused_cs_edges[1]));
  silife_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .i_pin(i_load_clk),
    .o_sync(unused_clk_sync), .o_rise(clk_rise), .o_fall(clk_fall));
  silife_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk), .reset(reset), .i_pin(i_load_data),
    .o_sync(data_s), .o_rise(unused_data_edges[0]), .o_fall(unused_data_edges[1]));

  loader_state_e       state_q, state_d;
  logic [SEG_BITS-1:0] local_q, local_d;
  logic [SEG_BITS-1:0] seg_q, seg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ROW_W-1:0]    row_q, row_d, row_sel_q, row_sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                cmd_q, cmd_d;
  logic                req_vld_q, req_vld_d, req_bit_q, req_bit_d;
  logic [IDX_W-1:0]    req_idx_q, req_idx_d;
  logic [ROW_W-1:0]    req_row_q, req_row_d;
  logic [WIDTH-1:0]    set_q, set_d, clr_q, clr_d, onehot;
  logic                out_q, out_d;
  logic                sel;
  logic                last_row_bit;

  assign sel          = (seg_q == local_q) || (&seg_q);
  assign last_row_bit = (bit_cnt_q == CNT_W'(ROW_ADDR_FRAME_BITS - 1));
  assign onehot       = {{(WIDTH-1){1'b0}}, 1'b1} << req_idx_q;

`ifdef SILIFE_LOADER_READBACK_EN
  logic [WIDTH-1:0] shadow_q;
  logic [1:0]       shd_cnt_q, shd_cnt_d;
  logic             shd_evt;

  // A new row becomes visible on o_row_select two clks after the event and
  // i_row_cells settles one clk after that, hence the 3-clk countdown.
  assign shd_evt = clk_rise && !cs_s &&
                   ((state_q == ST_ROW_ADDR && last_row_bit && cmd_q == CMD_READ) ||
                    (state_q == ST_READ && (&idx_q)));

  always_comb begin
    shd_cnt_d = shd_cnt_q;
    if (cs_s)                  shd_cnt_d = 2'd0;
    else if (shd_evt)          shd_cnt_d = 2'd3;
    else if (shd_cnt_q != 2'd0) shd_cnt_d = shd_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shd_cnt_q <= 2'd0;
    else       shd_cnt_q <= shd_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (shd_cnt_q == 2'd1) shadow_q <= i_row_cells;
  end
`else
  logic unused_row_cells, unused_clk_fall;
  assign unused_row_cells = ^i_row_cells;
  assign unused_clk_fall  = clk_fall;
`endif

  // Frame decoding: one serial bit per synchronised rise; cs high aborts.
  always_comb begin
    state_d   = state_q;
    local_d   = local_q;
    seg_d     = seg_q;
    bit_cnt_d = bit_cnt_q;
    row_d     = row_q;
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    req_vld_d = 1'b0;
    req_bit_d = data_s;
    req_idx_d = idx_q;
    req_row_d = row_q;
    if (cs_s) begin
      state_d   = ST_IDLE;
      seg_d     = '0;
      bit_cnt_d = '0;
      row_d     = '0;
      idx_d     = '0;
      cmd_d     = CMD_WRITE;
    end else if (clk_rise) begin
      unique case (state_q)
        ST_IDLE:      state_d = data_s ? ST_CONFIGURE : ST_CMD;
        ST_CONFIGURE: if (data_s) local_d = local_q + SEG_BITS'(1);
        ST_CMD: begin
          cmd_d     = data_s;
          bit_cnt_d = '0;
`ifdef SILIFE_LOADER_READBACK_EN
          state_d   = ST_SEG_ADDR;
`else
          state_d   = (data_s == CMD_READ) ? ST_IGNORE : ST_SEG_ADDR;
`endif
        end
        ST_SEG_ADDR: begin
          seg_d = {data_s, seg_q[SEG_BITS-1:1]};
          if (bit_cnt_q == CNT_W'(SEG_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_ROW_ADDR;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_ROW_ADDR: begin
          // Address bits beyond the grid height are discarded.
          for (int i = 0; i < ROW_W; i++)
            if (bit_cnt_q == CNT_W'(i)) row_d[i] = data_s;
          if (last_row_bit) begin
            bit_cnt_d = '0;
            idx_d     = '0;
            state_d   = (cmd_q == CMD_READ) ? ST_READ : ST_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_WRITE, ST_READ: begin
          req_vld_d = (state_q == ST_WRITE) && sel;
          idx_d     = idx_q + IDX_W'(1);
          if (&idx_q) row_d = row_q + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pulse stage and serial-out register.
  always_comb begin
    set_d     = '0;
    clr_d     = '0;
    if (req_vld_q && !cs_s) begin
      if (req_bit_q) set_d = onehot;
      else           clr_d = onehot;
    end
    // Hold the row of an in-flight pulse so it lines up with its row select.
    row_sel_d = req_vld_q ? req_row_q : row_q;
    out_d     = data_s;
    if (state_q == ST_CONFIGURE) out_d = 1'b1;
`ifdef SILIFE_LOADER_READBACK_EN
    else if (state_q == ST_READ && sel) out_d = clk_fall ? shadow_q[idx_q] : out_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      local_q   <= '0;
      seg_q     <= '0;
      bit_cnt_q <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      cmd_q     <= CMD_WRITE;
      req_vld_q <= 1'b0;
      set_q     <= '0;
      clr_q     <= '0;
      row_sel_q <= '0;
      out_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      local_q   <= local_d;
      seg_q     <= seg_d;
      bit_cnt_q <= bit_cnt_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      req_vld_q <= req_vld_d;
      set_q     <= set_d;
      clr_q     <= clr_d;
      row_sel_q <= row_sel_d;
      out_q     <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    req_bit_q <= req_bit_d;
    req_idx_q <= req_idx_d;
    req_row_q <= req_row_d;
  end

  assign o_set_cells         = cs_s ? '0 : set_q;
  assign o_clear_cells       = cs_s ? '0 : clr_q;
  assign o_row_select        = row_sel_q;
  assign o_load_data         = out_q;
  assign o_selected          = sel && (state_q == ST_WRITE || state_q == ST_READ);
  assign o_dbg_local_address = local_q;

endmodule

// File: tb/tb_silife_grid_loader_rw.sv
module tb_silife_grid_loader_rw;

  localparam int WIDTH    = 32;
  localparam int HEIGHT   = 32;
  localparam int SEG_BITS = 15;
  localparam int SYNC     = 2;
  localparam int H        = 6;   // serial half-period in clks

  logic clk = 1'b0;
  logic reset, cs, sclk, sdata;
  logic o_load_data, o_selected;
  logic [WIDTH-1:0] i_row_cells, o_set, o_clr;
  logic [$clog2(HEIGHT)-1:0] o_row_select;
  logic [SEG_BITS-1:0] o_dbg;

  always #5 clk = ~clk;

  silife_grid_loader_rw #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SEG_BITS(SEG_BITS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .i_load_cs(cs), .i_load_clk(sclk), .i_load_data(sdata),
    .o_load_data(o_load_data), .i_row_cells(i_row_cells), .o_selected(o_selected),
    .o_row_select(o_row_select), .o_set_cells(o_set), .o_clear_cells(o_clr),
    .o_dbg_local_address(o_dbg));

  // Behavioural grid: the row the DUT selects is presented on i_row_cells.
  logic [WIDTH-1:0] grid [HEIGHT];
  always_comb i_row_cells = grid[o_row_select];

  int checks = 0;
  int failures = 0;
  int exp_local = 0;

  typedef struct { int row; int idx; bit set; } ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];

  // Every cycle a pulse bit is high is one event; a two-clk pulse shows up twice.
  always @(negedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (o_set[i]) obs_q.push_back('{int'(o_row_select), i, 1'b1});
      if (o_clr[i]) obs_q.push_back('{int'(o_row_select), i, 1'b0});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ev_code(input ev_t e);
    return {16'(e.row), 16'(e.idx), 31'b0, e.set};
  endfunction

  task automatic sbit(input logic b, output logic smp);
    sdata = b;
    repeat (H) @(negedge clk);
    smp  = o_load_data;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    logic d;
    for (int k = 0; k < n; k++) sbit(v[k], d);
  endtask

  task automatic start_frame();
    @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic compare_events(input string nm);
    chk({nm, " event count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({nm, " event"}, ev_code(obs_q[i]), ev_code(exp_q[i]));
  endtask

  task automatic write_header(input logic [SEG_BITS-1:0] seg, input logic [15:0] row);
    send_bits(64'd0, 1);           // start bit: Idle -> Cmd
    send_bits(64'd0, 1);           // write command
    send_bits(64'(seg), SEG_BITS);
    send_bits(64'(row), 16);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_write(input string nm, input logic [SEG_BITS-1:0] seg,
                           input logic [15:0] row, input int n, input logic [63:0] data);
    bit sel;
    int r0;
    sel = (int'(seg) == exp_local) || (&seg);
    r0  = int'(row) % HEIGHT;
    obs_q.delete();
    exp_q.delete();
    start_frame();
    write_header(seg, row);
    chk({nm, " row_select"}, 64'(o_row_select), 64'(r0));
    chk({nm, " selected"}, 64'(o_selected), 64'(sel));
    send_bits(data, n);
    if (sel)
      for (int k = 0; k < n; k++)
        exp_q.push_back('{(r0 + k / WIDTH) % HEIGHT, k % WIDTH, data[k]});
    end_frame();
    compare_events(nm);
  endtask

  typedef struct {
    logic [SEG_BITS-1:0] seg;
    logic [15:0]         row;
    int                  n;
    logic [63:0]         data;
    bit                  rnd;
  } wvec_t;
  wvec_t tbl[6];

  initial begin
    logic smp;
    logic [63:0] d;
    logic [15:0] cfg;
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; sdata = 1'b0;
    for (int r = 0; r < HEIGHT; r++) grid[r] = WIDTH'($urandom);
    grid[2] = 32'hA5A5_0001;

    tbl[0] = '{15'd0,      16'd5,      32, 64'h1, 1'b0};  // set bit0, clear 1..31
    tbl[1] = '{15'd0,      16'd31,     64, 64'h0, 1'b1};  // wraps to row 0
    tbl[2] = '{15'd7,      16'd3,      12, 64'h0, 1'b1};  // other segment
    tbl[3] = '{15'h7fff,   16'd9,      16, 64'h0, 1'b1};  // broadcast
    tbl[4] = '{15'd0,      16'h1234,   20, 64'h0, 1'b1};  // high row bits dropped
    tbl[5] = '{15'd0,      16'd30,     40, 64'h0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset load_data", 64'(o_load_data), 64'd1);
    chk("reset set", 64'(o_set), 64'd0);
    chk("reset clear", 64'(o_clr), 64'd0);
    chk("reset selected", 64'(o_selected), 64'd0);
    chk("reset row_select", 64'(o_row_select), 64'd0);
    chk("reset local_address", 64'(o_dbg), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven write frames
    for (int t = 0; t < 6; t++) begin
      d = tbl[t].rnd ? {$urandom, $urandom} : tbl[t].data;
      run_write($sformatf("write%0d", t), tbl[t].seg, tbl[t].row, tbl[t].n, d);
    end

    // Configure: 1 enters, then 1,0,1,1 -> +3; o_load_data held at 1
    cfg = 16'b11011;
    start_frame();
    for (int k = 0; k < 5; k++) begin
      sbit(cfg[k], smp);
      if (k >= 1) chk("configure load_data", 64'(smp), 64'd1);
      if (k >= 1 && cfg[k]) exp_local++;
    end
    end_frame();
    chk("configure local 1", 64'(o_dbg), 64'(exp_local));
    start_frame();
    send_bits(64'b11, 2);
    exp_local++;
    end_frame();
    chk("configure local 2", 64'(o_dbg), 64'(exp_local));

    run_write("write_cfg_hit", SEG_BITS'(exp_local), 16'd12, 10, {$urandom, $urandom});
    run_write("write_cfg_miss", 15'd0, 16'd12, 10, {$urandom, $urandom});

`ifdef SILIFE_LOADER_READBACK_EN
    // Read-back of row 2 then into row 3, LSB first
    obs_q.delete();
    start_frame();
    send_bits(64'd0, 1);
    send_bits(64'd1, 1);
    send_bits(64'(exp_local), SEG_BITS);
    send_bits(64'd2, 16);
    for (int k = 0; k < 40; k++) begin
      sbit(1'($urandom), smp);
      chk($sformatf("read bit%0d", k), 64'(smp), 64'(grid[(2 + k / WIDTH) % HEIGHT][k % WIDTH]));
    end
    end_frame();
    chk("read no pulses", obs_q.size(), 64'd0);
`else
    // Read command without read-back: ignored, data passes through
    obs_q.delete();
    start_frame();
    send_bits(64'd0, 1);
    send_bits(64'd1, 1);
    for (int k = 0; k < 16; k++) begin
      d[0] = 1'($urandom);
      sbit(d[0], smp);
      chk("ignore passthrough", 64'(smp), 64'(d[0]));
    end
    chk("ignore selected", 64'(o_selected), 64'd0);
    end_frame();
    chk("ignore no pulses", obs_q.size(), 64'd0);
`endif

    // cs raised mid-row
    obs_q.delete();
    exp_q.delete();
    d = {$urandom, $urandom};
    start_frame();
    write_header(SEG_BITS'(exp_local), 16'd7);
    send_bits(d, 10);
    for (int k = 0; k < 10; k++) exp_q.push_back('{7, k, d[k]});
    cs = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    chk("abort set", 64'(o_set), 64'd0);
    chk("abort clear", 64'(o_clr), 64'd0);
    chk("abort selected", 64'(o_selected), 64'd0);
    chk("abort row_select", 64'(o_row_select), 64'd0);
    chk("abort local kept", 64'(o_dbg), 64'(exp_local));
    repeat (8) @(negedge clk);
    compare_events("abort");
    run_write("after_abort", SEG_BITS'(exp_local), 16'd1, 6, {$urandom, $urandom});

    // Reset asserted mid-frame
    start_frame();
    write_header(SEG_BITS'(exp_local), 16'd6);
    send_bits(64'h5, 3);
    chk("pre-reset selected", 64'(o_selected), 64'd1);
    chk("pre-reset row_select", 64'(o_row_select), 64'd6);
    reset = 1'b1;
    #1;
    chk("mid reset selected", 64'(o_selected), 64'd0);
    chk("mid reset row_select", 64'(o_row_select), 64'd0);
    chk("mid reset local", 64'(o_dbg), 64'd0);
    chk("mid reset load_data", 64'(o_load_data), 64'd1);
    chk("mid reset set", 64'(o_set), 64'd0);
    exp_local = 0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    run_write("after_reset", 15'd0, 16'd4, 8, {$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
